// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the RAM.
// slave: the arbiter's view; master: the surrounding logic (CPU, SPI wrapper, RAM).
interface imem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  prog_wr_en;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_instr;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_oe;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_pending;
  logic                  wr_overflow;

  modport slave (
    input  prog_wr_en, prog_addr, prog_instr, fetch_req, fetch_addr, ram_rd_data,
    output fetch_gnt, fetch_valid, fetch_data, ram_addr, ram_we, ram_oe,
           ram_wr_data, wr_pending, wr_overflow
  );

  modport master (
    output prog_wr_en, prog_addr, prog_instr, fetch_req, fetch_addr, ram_rd_data,
    input  fetch_gnt, fetch_valid, fetch_data, ram_addr, ram_we, ram_oe,
           ram_wr_data, wr_pending, wr_overflow
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction RAM between CPU fetches and SPI programming
// writes: 2-entry write buffer, write priority, fetch starvation guard, RAW protection.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic clk,
  input  logic rst,
  imem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {GNT_IDLE, GNT_WRITE, GNT_FETCH} gnt_e;

  logic [ADDR_WIDTH-1:0] buf_addr_reg [2];
  logic [DATA_WIDTH-1:0] buf_data_reg [2];
  logic                  head_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic [2:0]            wait_reg;
  logic [2:0]            wait_next;
  logic                  fetch_valid_reg;
  logic [DATA_WIDTH-1:0] fetch_data_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_wr_data_reg;
  logic                  overflow_reg;

  gnt_e                  gnt_next;
  logic [1:0]            entry_hit;
  logic                  haz;
  logic                  starve;
  logic                  pop;
  logic                  push_ok;
  logic                  tail;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic slot_off;
      // Distance of this slot from the head decides whether it holds a live entry.
      assign slot_off      = 1'(gi) ^ head_reg;
      assign entry_hit[gi] = ({1'b0, slot_off} < count_reg) &&
                             (buf_addr_reg[gi] == bus.fetch_addr);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_addr_reg[gi] <= '0;
          buf_data_reg[gi] <= '0;
        end else if (push_ok && (tail == 1'(gi))) begin
          buf_addr_reg[gi] <= bus.prog_addr;
          buf_data_reg[gi] <= bus.prog_instr;
        end
      end
    end
  endgenerate

  // A write arriving this cycle also blocks a same-address fetch, so the fetch
  // waits for the write to reach the RAM instead of returning stale data.
  assign haz    = (|entry_hit) ||
                  (bus.prog_wr_en && (bus.prog_addr == bus.fetch_addr));
  assign starve = (wait_reg >= 3'(MAX_WAIT));

  always_comb begin
    gnt_next = GNT_IDLE;
    if (bus.fetch_req && !haz && ((count_reg == 2'd0) || starve))
      gnt_next = GNT_FETCH;
    else if (count_reg != 2'd0)
      gnt_next = GNT_WRITE;
  end

  assign pop     = (gnt_next == GNT_WRITE);
  assign push_ok = bus.prog_wr_en && ((count_reg != 2'd2) || pop);
  // With two entries and a pop, the freed head slot takes the new entry.
  assign tail    = head_reg ^ count_reg[0];

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)
      count_next = count_reg + 2'd1;
    else if (!push_ok && pop)
      count_next = count_reg - 2'd1;
  end

  always_comb begin
    wait_next = wait_reg;
    if (!bus.fetch_req || (gnt_next == GNT_FETCH))
      wait_next = 3'd0;
    else if (wait_reg != 3'd7)
      wait_next = wait_reg + 3'd1;
  end

  assign bus.fetch_gnt   = (gnt_next == GNT_FETCH);
  assign bus.ram_we      = (gnt_next == GNT_WRITE);
  assign bus.ram_oe      = (gnt_next == GNT_FETCH);
  assign bus.ram_addr    = (gnt_next == GNT_FETCH) ? bus.fetch_addr :
                           (gnt_next == GNT_WRITE) ? buf_addr_reg[head_reg] :
                                                     ram_addr_reg;
  assign bus.ram_wr_data = (gnt_next == GNT_WRITE) ? buf_data_reg[head_reg] :
                                                     ram_wr_data_reg;
  assign bus.fetch_valid = fetch_valid_reg;
  // RAM data arrives the cycle after the grant; it is captured then and held.
  assign bus.fetch_data  = fetch_valid_reg ? bus.ram_rd_data : fetch_data_reg;
  assign bus.wr_pending  = (count_reg != 2'd0);
  assign bus.wr_overflow = overflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg        <= 1'b0;
      count_reg       <= 2'd0;
      wait_reg        <= 3'd0;
      fetch_valid_reg <= 1'b0;
      fetch_data_reg  <= '0;
      ram_addr_reg    <= '0;
      ram_wr_data_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      count_reg       <= count_next;
      wait_reg        <= wait_next;
      fetch_valid_reg <= (gnt_next == GNT_FETCH);
      if (pop)
        head_reg <= ~head_reg;
      if (fetch_valid_reg)
        fetch_data_reg <= bus.ram_rd_data;
      if (gnt_next != GNT_IDLE) begin
        ram_addr_reg    <= bus.ram_addr;
        ram_wr_data_reg <= bus.ram_wr_data;
      end
      if (bus.prog_wr_en && !push_ok)
        overflow_reg <= 1'b1;
    end
  end
endmodule
